// File: rtl/alu_result_monitor.sv
// In-silicon self-check for the 2-bit ALU: recomputes each issued op, delays it by LAT and compares with f.
// Define ALU_MON_CAPTURE_EN to latch the operands/result of the first mismatch on the cap_* outputs.
module alu_result_monitor #(
    parameter int LAT         = 1,
    parameter int CNT_W       = 8,
    parameter int STOP_ON_ERR = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             in_valid,
    input  logic [1:0]       a,
    input  logic [1:0]       b,
    input  logic [2:0]       s,
    input  logic [3:0]       f,
    output logic             chk_pulse,
    output logic             mis_pulse,
    output logic [CNT_W-1:0] chk_count,
    output logic [CNT_W-1:0] err_count,
    output logic             fail,
    output logic [1:0]       state
`ifdef ALU_MON_CAPTURE_EN
    ,
    output logic [1:0]       cap_a,
    output logic [1:0]       cap_b,
    output logic [2:0]       cap_s,
    output logic [3:0]       cap_f,
    output logic [3:0]       cap_exp
`endif
);

    typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, FAILST = 2'b10} state_t;

    typedef struct packed {
`ifdef ALU_MON_CAPTURE_EN
        logic [1:0] a;
        logic [1:0] b;
        logic [2:0] s;
`endif
        logic [3:0] gold;
    } op_t;

    function automatic logic [3:0] golden(input logic [1:0] ga, input logic [1:0] gb,
                                          input logic [2:0] gs);
        logic [3:0] xa, xb;
        xa = {2'b00, ga};
        xb = {2'b00, gb};
        case (gs)
            3'b000:  golden = xa + xb;
            3'b001:  golden = xa - xb;
            3'b010:  golden = xa & xb;
            3'b011:  golden = xa | xb;
            3'b100:  golden = xa ^ xb;
            3'b101:  golden = xa * xb;
            3'b110:  golden = {2'b00, ~ga};
            default: golden = {ga, gb};
        endcase
    endfunction

    state_t     st_q, st_d;
    logic       accept, cmp, mis;
    op_t        op_in;
    logic [LAT:1] vld_pipe;
    op_t        op_pipe [LAT:1];

    assign accept = in_valid && (st_q == RUN);

    always_comb begin
        op_in      = '0;
        op_in.gold = golden(a, b, s);
`ifdef ALU_MON_CAPTURE_EN
        op_in.a    = a;
        op_in.b    = b;
        op_in.s    = s;
`endif
    end

    // Only the valid bits need clearing; stale payload is never looked at.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
        end else if (clr) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[1] <= accept;
            for (int k = 2; k <= LAT; k++) vld_pipe[k] <= vld_pipe[k-1];
        end
    end

    always_ff @(posedge clk) begin
        op_pipe[1] <= op_in;
        for (int k = 2; k <= LAT; k++) op_pipe[k] <= op_pipe[k-1];
    end

    // In-flight ops still compare after RUN->IDLE, but FAIL freezes everything.
    assign cmp = vld_pipe[LAT] && (st_q != FAILST);
    assign mis = cmp && (f != op_pipe[LAT].gold);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) st_q <= IDLE;
        else     st_q <= st_d;
    end

    always_comb begin
        st_d = st_q;
        if (clr) begin
            st_d = IDLE;
        end else begin
            case (st_q)
                IDLE:    if (en) st_d = RUN;
                RUN: begin
                    if (mis && (STOP_ON_ERR != 0)) st_d = FAILST;
                    else if (!en)                  st_d = IDLE;
                end
                FAILST:  st_d = FAILST;
                default: st_d = IDLE;
            endcase
        end
    end

    always_comb begin
        state = st_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chk_pulse <= 1'b0;
            mis_pulse <= 1'b0;
            chk_count <= '0;
            err_count <= '0;
            fail      <= 1'b0;
        end else if (clr) begin
            chk_pulse <= 1'b0;
            mis_pulse <= 1'b0;
            chk_count <= '0;
            err_count <= '0;
            fail      <= 1'b0;
        end else begin
            chk_pulse <= cmp;
            mis_pulse <= mis;
            if (cmp && (chk_count != '1)) chk_count <= chk_count + 1'b1;
            if (mis && (err_count != '1)) err_count <= err_count + 1'b1;
            if (mis) fail <= 1'b1;
        end
    end

`ifdef ALU_MON_CAPTURE_EN
    // fail is still low on the edge of the first mismatch, so this latches exactly once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_a   <= '0;
            cap_b   <= '0;
            cap_s   <= '0;
            cap_f   <= '0;
            cap_exp <= '0;
        end else if (clr) begin
            cap_a   <= '0;
            cap_b   <= '0;
            cap_s   <= '0;
            cap_f   <= '0;
            cap_exp <= '0;
        end else if (mis && !fail) begin
            cap_a   <= op_pipe[LAT].a;
            cap_b   <= op_pipe[LAT].b;
            cap_s   <= op_pipe[LAT].s;
            cap_f   <= f;
            cap_exp <= op_pipe[LAT].gold;
        end
    end
`endif

endmodule

// File: tb/tb_alu_result_monitor.sv
// Scoreboard bench for alu_result_monitor: five instances with different LAT/CNT_W/STOP_ON_ERR
// share one op bus; the bench supplies f through a delay line matching each instance's latency.
module tb_alu_result_monitor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, clr, in_valid;
    logic [4:0] en;
    logic [1:0] a, b;
    logic [2:0] s;
    logic [3:0] fcur;
    logic [3:0] fdly [1:4];
    int         cyc = 0;

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        fdly[1] <= fcur;
        fdly[2] <= fdly[1];
        fdly[3] <= fdly[2];
        fdly[4] <= fdly[3];
    end

    logic [4:0]      chk_p, mis_p, failv;
    logic [4:0][7:0] chk_c, err_c;
    logic [4:0][1:0] st;
`ifdef ALU_MON_CAPTURE_EN
    logic [4:0][1:0] ca, cb;
    logic [4:0][2:0] cs;
    logic [4:0][3:0] cf, ce;
`endif

    function automatic int lat_of(int i);
        case (i)
            3:       return 3;
            4:       return 2;
            default: return 1;
        endcase
    endfunction
    function automatic int cw_of(int i);
        return (i == 2) ? 2 : 8;
    endfunction
    function automatic int stop_of(int i);
        return (i == 1) ? 1 : 0;
    endfunction

    for (genvar g = 0; g < 5; g++) begin : gi
        localparam int L  = lat_of(g);
        localparam int CW = cw_of(g);
        logic [CW-1:0] cc, ec;
        alu_result_monitor #(.LAT(L), .CNT_W(CW), .STOP_ON_ERR(stop_of(g))) u_dut (
            .clk       (clk),
            .rst       (rst),
            .en        (en[g]),
            .clr       (clr),
            .in_valid  (in_valid),
            .a         (a),
            .b         (b),
            .s         (s),
            .f         (fdly[L]),
            .chk_pulse (chk_p[g]),
            .mis_pulse (mis_p[g]),
            .chk_count (cc),
            .err_count (ec),
            .fail      (failv[g]),
            .state     (st[g])
`ifdef ALU_MON_CAPTURE_EN
            ,
            .cap_a     (ca[g]),
            .cap_b     (cb[g]),
            .cap_s     (cs[g]),
            .cap_f     (cf[g]),
            .cap_exp   (ce[g])
`endif
        );
        assign chk_c[g] = 8'(cc);
        assign err_c[g] = 8'(ec);
    end

    typedef struct {
        logic mis;
        int   chk;
        int   err;
        logic fl;
        int   cyc;
    } exp_t;

    exp_t sbq [5][$];
    int   e_chk [5];
    int   e_err [5];
    logic e_fail [5];
    int   n_cmp = 0;
    int   n_mis = 0;

    task automatic check(input string name, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_mis++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 5; i++) begin
            e_chk[i]  = 0;
            e_err[i]  = 0;
            e_fail[i] = 1'b0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    // ef: hand-computed ALU result; fv: value the fake ALU actually returns.
    task automatic issue(input int i, input logic [1:0] ia, input logic [1:0] ib,
                         input logic [2:0] is, input logic [3:0] ef, input logic [3:0] fv,
                         input bit acc);
        exp_t e;
        int   mx;
        in_valid = 1'b1;
        a        = ia;
        b        = ib;
        s        = is;
        fcur     = fv;
        if (acc) begin
            mx = (1 << cw_of(i)) - 1;
            if (e_chk[i] < mx) e_chk[i]++;
            if (fv != ef) begin
                if (e_err[i] < mx) e_err[i]++;
                e_fail[i] = 1'b1;
            end
            e.mis = (fv != ef);
            e.chk = e_chk[i];
            e.err = e_err[i];
            e.fl  = e_fail[i];
            e.cyc = cyc + 1 + lat_of(i);
            sbq[i].push_back(e);
        end
        step();
    endtask

    task automatic drain(input int i);
        for (int k = 0; k < 30; k++) begin
            if (sbq[i].size() == 0) break;
            step();
        end
        check($sformatf("drain_dut%0d", i), sbq[i].size(), 0);
    endtask

    task automatic check_zero(input int i, input string tag);
        check($sformatf("%s_state%0d", tag, i), int'(st[i]), 0);
        check($sformatf("%s_chk%0d", tag, i), int'(chk_c[i]), 0);
        check($sformatf("%s_err%0d", tag, i), int'(err_c[i]), 0);
        check($sformatf("%s_fail%0d", tag, i), int'(failv[i]), 0);
        check($sformatf("%s_pulse%0d", tag, i), int'(chk_p[i]), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; clr = 1'b0; en = '0; in_valid = 1'b0;
        a = '0; b = '0; s = '0; fcur = '0;
        model_clear();

        fork
            begin : mon
                exp_t e;
                forever begin
                    @(negedge clk);
                    for (int i = 0; i < 5; i++) begin
                        if (chk_p[i]) begin
                            if (sbq[i].size() == 0) begin
                                check($sformatf("unexpected_chk_dut%0d", i), int'(chk_p[i]), 0);
                            end else begin
                                e = sbq[i].pop_front();
                                check($sformatf("mis_pulse_dut%0d", i), int'(mis_p[i]), int'(e.mis));
                                check($sformatf("chk_count_dut%0d", i), int'(chk_c[i]), e.chk);
                                check($sformatf("err_count_dut%0d", i), int'(err_c[i]), e.err);
                                check($sformatf("fail_dut%0d", i), int'(failv[i]), int'(e.fl));
                                check($sformatf("latency_dut%0d", i), cyc, e.cyc);
                            end
                        end else if (mis_p[i]) begin
                            check($sformatf("mis_without_chk_dut%0d", i), int'(mis_p[i]), int'(chk_p[i]));
                        end
                    end
                end
            end
        join_none

        repeat (3) step();
        for (int i = 0; i < 5; i++) check_zero(i, "reset");
        rst = 1'b0;
        step();

        // LAT=1 basic ops, one deliberate mismatch (xor expected 0001, ALU returns 0000)
        en[0] = 1'b1;
        step();
        check("run_state0", int'(st[0]), 1);
        issue(0, 2'b10, 2'b00, 3'b000, 4'b0010, 4'b0010, 1);
        issue(0, 2'b01, 2'b10, 3'b001, 4'b1111, 4'b1111, 1);
        issue(0, 2'b11, 2'b11, 3'b101, 4'b1001, 4'b1001, 1);
        issue(0, 2'b10, 2'b11, 3'b010, 4'b0010, 4'b0010, 1);
        issue(0, 2'b10, 2'b01, 3'b011, 4'b0011, 4'b0011, 1);
        issue(0, 2'b01, 2'b00, 3'b100, 4'b0001, 4'b0000, 1);
        issue(0, 2'b10, 2'b00, 3'b110, 4'b0001, 4'b0001, 1);
        issue(0, 2'b10, 2'b11, 3'b111, 4'b1011, 4'b1011, 1);
        idle();
        drain(0);
        check("a_chk_total", int'(chk_c[0]), 8);
        check("a_err_total", int'(err_c[0]), 1);
        check("a_fail", int'(failv[0]), 1);
        check("a_state_run", int'(st[0]), 1);
`ifdef ALU_MON_CAPTURE_EN
        check("cap_exp", int'(ce[0]), 1);
        check("cap_f", int'(cf[0]), 0);
        check("cap_a", int'(ca[0]), 1);
        check("cap_b", int'(cb[0]), 0);
        check("cap_s", int'(cs[0]), 4);
`endif
        en[0] = 1'b0;
        clr = 1'b1;
        step();
        clr = 1'b0;
        model_clear();
        check_zero(0, "a_clr");
`ifdef ALU_MON_CAPTURE_EN
        check("cap_exp_clr", int'(ce[0]), 0);
`endif

        // STOP_ON_ERR: first mismatch freezes the monitor in FAIL
        en[1] = 1'b1;
        step();
        issue(1, 2'b01, 2'b01, 3'b000, 4'b0010, 4'b0111, 1);
        idle();
        drain(1);
        step();
        check("b_state_fail", int'(st[1]), 2);
        issue(1, 2'b00, 2'b01, 3'b000, 4'b0001, 4'b0001, 0);
        issue(1, 2'b11, 2'b01, 3'b011, 4'b0011, 4'b0011, 0);
        issue(1, 2'b10, 2'b10, 3'b100, 4'b0000, 4'b0000, 0);
        issue(1, 2'b01, 2'b11, 3'b111, 4'b0111, 4'b0111, 0);
        issue(1, 2'b11, 2'b10, 3'b001, 4'b0001, 4'b0001, 0);
        idle();
        repeat (4) step();
        check("b_state_hold", int'(st[1]), 2);
        check("b_chk_frozen", int'(chk_c[1]), 1);
        check("b_err_frozen", int'(err_c[1]), 1);
        check("b_fail_sticky", int'(failv[1]), 1);
        clr = 1'b1;
        step();
        clr = 1'b0;
        model_clear();
        check_zero(1, "b_clr");
        step();
        check("b_run_after_clr", int'(st[1]), 1);
        en[1] = 1'b0;
        step();

        // CNT_W=2: counters saturate at 3
        en[2] = 1'b1;
        step();
        issue(2, 2'b00, 2'b01, 3'b000, 4'b0001, 4'b0001, 1);
        issue(2, 2'b11, 2'b01, 3'b011, 4'b0011, 4'b0011, 1);
        issue(2, 2'b10, 2'b10, 3'b100, 4'b0000, 4'b0000, 1);
        issue(2, 2'b01, 2'b11, 3'b111, 4'b0111, 4'b0111, 1);
        issue(2, 2'b11, 2'b10, 3'b001, 4'b0001, 4'b0001, 1);
        idle();
        drain(2);
        check("c_chk_sat", int'(chk_c[2]), 3);
        check("c_err_zero", int'(err_c[2]), 0);
        en[2] = 1'b0;
        step();

        // LAT=3: reset in the middle of the pipeline discards in-flight ops
        en[3] = 1'b1;
        step();
        issue(3, 2'b01, 2'b01, 3'b010, 4'b0001, 4'b0001, 0);
        issue(3, 2'b10, 2'b01, 3'b011, 4'b0011, 4'b0011, 0);
        a = 2'b11; b = 2'b00; s = 3'b110; fcur = 4'b0000;
        rst = 1'b1;
        #1;
        check_zero(3, "d_rst");
        step();
        step();
        check_zero(3, "d_rst_hold");
        rst = 1'b0;
        in_valid = 1'b0;
        model_clear();
        step();
        issue(3, 2'b11, 2'b10, 3'b000, 4'b0101, 4'b0101, 1);
        idle();
        drain(3);
        check("d_chk_after_rst", int'(chk_c[3]), 1);
        en[3] = 1'b0;
        step();

        // LAT=2: dropping en still lets in-flight ops compare; later ops are ignored
        en[4] = 1'b1;
        step();
        issue(4, 2'b10, 2'b11, 3'b000, 4'b0101, 4'b0101, 1);
        issue(4, 2'b01, 2'b11, 3'b101, 4'b0011, 4'b0011, 1);
        en[4] = 1'b0;
        idle();
        step();
        issue(4, 2'b11, 2'b01, 3'b000, 4'b0100, 4'b0100, 0);
        idle();
        step();
        issue(4, 2'b11, 2'b01, 3'b000, 4'b0100, 4'b0100, 0);
        idle();
        drain(4);
        repeat (4) step();
        check("e_state_idle", int'(st[4]), 0);
        check("e_chk_total", int'(chk_c[4]), 2);
        check("e_err_zero", int'(err_c[4]), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/alu_result_monitor.md
Name: alu_result_monitor

Overview:
- Hardware-side counterpart to the ALU stimulus path. It observes each operation issued to the registered 2-bit ALU as operands, opcode and valid, plus the ALU result f.
- Computes the golden result internally, aligns it to the ALU pipeline latency, and compares it against f.
- Maintains pass/error counters and a sticky fail flag so the board can run self-check in silicon without a simulator.
- Sits beside the alu instance, tapping the same a/b/s/clk nets and f.

Parameters:
- LAT, 1, ALU result latency in clk cycles from operand sample to valid f; legal range 1..4.
- CNT_W, 8, width of check and error counters.
- STOP_ON_ERR, 0, when 1 the monitor enters FAIL on the first mismatch and freezes all counters.

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  asynchronous, active-high reset
- en  input  1  monitor enable; no checks are issued while low
- clr  input  1  synchronous clear of counters, flags and state back to IDLE
- in_valid  input  1  a/b/s this cycle form an operation to check
- a  input  2  ALU operand A
- b  input  2  ALU operand B
- s  input  3  ALU opcode
- f  input  4  ALU result
- chk_pulse  output  1  one-cycle pulse when a comparison is made
- mis_pulse  output  1  one-cycle pulse when that comparison fails
- chk_count  output  CNT_W  number of comparisons made
- err_count  output  CNT_W  number of mismatches
- fail  output  1  sticky, set on first mismatch
- state  output  2  00 IDLE, 01 RUN, 10 FAIL

Behaviour:
- Reset is asynchronous and active-high on rst. Everything is clocked by the single clock clk.
- While rst is high, all outputs are 0, state is IDLE, and the pipeline valid bits are 0.
- Golden model, with a and b zero-extended to 4 bits and all results taken mod 16:
  - 000: a+b
  - 001: a-b (two's complement, 4-bit)
  - 010: a&b
  - 011: a|b
  - 100: a^b
  - 101: a*b
  - 110: {2'b00, ~a}
  - 111: {a, b}
- Alignment pipeline:
  - The expected value and its valid bit pass through a LAT-deep shift register.
  - The input valid is in_valid && state==RUN.
  - An op accepted at edge N is compared against f sampled at edge N+LAT.
- Comparison:
  - chk_pulse and mis_pulse are registered, so they assert the cycle after the compare edge.
  - A full pipeline accepts one op per cycle with no bubbles.
- State machine:
  - IDLE -> RUN when en=1.
  - RUN -> IDLE when en=0. In-flight ops already in the pipeline are still compared after this transition.
  - RUN -> FAIL on a mismatch, only if STOP_ON_ERR=1.
  - FAIL holds until clr or rst. In FAIL, new ops are not accepted and the counters freeze.
- Counters:
  - chk_count increments on each compare; err_count increments on each mismatch.
  - Both saturate at 2^CNT_W-1 and never wrap.
  - fail is set together with the first err_count increment.
- clr is synchronous and has priority over every other update in the same cycle. It zeroes the counters, fail, the pulses and the pipeline valid bits, and sets state to IDLE.
- rst asserted mid-pipeline discards all in-flight ops immediately; no compare is reported for them.
- If en and clr are both high, clr wins. RUN is entered on the following edge.
- in_valid while the state is IDLE is ignored silently.

Optional Feature:
- Macro ALU_MON_CAPTURE_EN.
- Defined:
  - Adds outputs cap_a[1:0], cap_b[1:0], cap_s[2:0], cap_f[3:0] and cap_exp[3:0].
  - These latch the operands, opcode, observed f and expected value of the first mismatch only.
  - They reset to 0 and are cleared by clr.
- Not defined:
  - The ports and registers are absent.
  - All other behaviour is identical.

Test Plan:
- LAT=1, en=1:
  - a=10, b=00, s=000, f=0010 on the next edge -> chk_pulse=1, mis_pulse=0, chk_count=1.
  - a=01, b=10, s=001 -> expected 1111, matched.
  - a=11, b=11, s=101 -> expected 1001, matched.
- Mismatch injection: a=01, b=00, s=100 with f forced to 0000 (expected 0001) -> mis_pulse=1, err_count=1, fail=1.
  - With ALU_MON_CAPTURE_EN: cap_exp=0001, cap_f=0000.
- STOP_ON_ERR=1: inject a mismatch, then 5 valid ops -> state=10, chk_count stays 1, err_count stays 1. Asserting clr -> all zero, state=00.
- CNT_W=2: 5 matching ops -> chk_count saturates at 3, err_count=0.
- LAT=3: issue 3 back-to-back ops, then assert rst after the second edge -> no chk_pulse is ever seen and all outputs read 0. After release, the next op compares exactly 3 cycles later.
- Drop en after issuing 2 ops with LAT=2 -> both are still compared, state returns to 00, and later in_valid pulses are ignored.
